// File: rtl/sys_cmd_master.sv
// Host-side UART command initiator: serializes one request into a byte frame,
// then collects the 0/1/2-byte response with an inter-byte timeout.
module sys_cmd_master #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned ADDR    = 4,
    parameter int unsigned TO_W    = 16,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CMD_VLD,
    input  logic [1:0]         CMD_TYPE,
    input  logic [ADDR-1:0]    CMD_ADDR,
    input  logic [WIDTH-1:0]   CMD_DATA,
    input  logic [WIDTH-1:0]   CMD_OPA,
    input  logic [WIDTH-1:0]   CMD_OPB,
    input  logic [3:0]         CMD_FUN,
    output logic               CMD_RDY,
    output logic [WIDTH-1:0]   TX_DATA,
    output logic               TX_VLD,
    input  logic               TX_BUSY,
    input  logic [WIDTH-1:0]   RX_DATA,
    input  logic               RX_VLD,
    output logic [2*WIDTH-1:0] RSP_DATA,
    output logic               CMD_DONE,
    output logic               RSP_TIMEOUT
);

    typedef enum logic [1:0] {StIdle, StSend, StWaitRsp, StDone} state_e;

    state_e               state_q, state_d;
    logic [1:0]           type_q, type_d;
    logic [ADDR-1:0]      addr_q, addr_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [WIDTH-1:0]     opa_q, opa_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic [3:0]           fun_q, fun_d;
    logic [1:0]           idx_q, idx_d;
    logic [1:0]           rx_cnt_q, rx_cnt_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic [2*WIDTH-1:0]   rsp_q, rsp_d;
    logic                 to_flag_q, to_flag_d;

    logic [1:0]           last_idx;
    logic [1:0]           rsp_num;
    logic [WIDTH-1:0]     frame_byte;
    logic [WIDTH-1:0]     addr_ext;
    logic [WIDTH-1:0]     fun_ext;
    logic [TO_W-1:0]      to_cnt_inc;
    logic [1:0]           rx_cnt_inc;

    assign addr_ext   = WIDTH'(addr_q);
    assign fun_ext    = WIDTH'(fun_q);
    assign to_cnt_inc = to_cnt_q + 1'b1;
    assign rx_cnt_inc = rx_cnt_q + 1'b1;

    // Frame length and expected response size per command type.
    always_comb begin
        last_idx = 2'd1;
        rsp_num  = 2'd0;
        unique case (type_q)
            2'b00: begin last_idx = 2'd2; rsp_num = 2'd0; end
            2'b01: begin last_idx = 2'd1; rsp_num = 2'd1; end
            2'b10: begin last_idx = 2'd3; rsp_num = 2'd2; end
            2'b11: begin last_idx = 2'd1; rsp_num = 2'd2; end
            default: ;
        endcase
    end

    always_comb begin
        frame_byte = '0;
        unique case (idx_q)
            2'd0: begin
                unique case (type_q)
                    2'b00:   frame_byte = WIDTH'(8'hAA);
                    2'b01:   frame_byte = WIDTH'(8'hBB);
                    2'b10:   frame_byte = WIDTH'(8'hCC);
                    default: frame_byte = WIDTH'(8'hDD);
                endcase
            end
            2'd1: begin
                unique case (type_q)
                    2'b10:   frame_byte = opa_q;
                    2'b11:   frame_byte = fun_ext;
                    default: frame_byte = addr_ext;
                endcase
            end
            2'd2:    frame_byte = (type_q == 2'b10) ? opb_q : data_q;
            default: frame_byte = fun_ext;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        addr_d    = addr_q;
        data_d    = data_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        fun_d     = fun_q;
        idx_d     = idx_q;
        rx_cnt_d  = rx_cnt_q;
        to_cnt_d  = to_cnt_q;
        rsp_d     = rsp_q;
        to_flag_d = to_flag_q;

        unique case (state_q)
            StIdle: begin
                if (CMD_VLD) begin
                    type_d    = CMD_TYPE;
                    addr_d    = CMD_ADDR;
                    data_d    = CMD_DATA;
                    opa_d     = CMD_OPA;
                    opb_d     = CMD_OPB;
                    fun_d     = CMD_FUN;
                    rsp_d     = '0;
                    idx_d     = '0;
                    rx_cnt_d  = '0;
                    to_cnt_d  = '0;
                    to_flag_d = 1'b0;
                    state_d   = StSend;
                end
            end
            StSend: begin
                if (!TX_BUSY) begin
                    if (idx_q == last_idx) begin
                        to_cnt_d = '0;
                        state_d  = (rsp_num == 2'd0) ? StDone : StWaitRsp;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StWaitRsp: begin
                // A byte arriving on the terminal cycle still wins over the timeout.
                if (RX_VLD) begin
                    if (rx_cnt_q == 2'd0) rsp_d[WIDTH-1:0]       = RX_DATA;
                    else                  rsp_d[2*WIDTH-1:WIDTH] = RX_DATA;
                    rx_cnt_d = rx_cnt_inc;
                    to_cnt_d = '0;
                    if (rx_cnt_inc == rsp_num) state_d = StDone;
                end else begin
                    to_cnt_d = to_cnt_inc;
                    if (to_cnt_inc == TO_W'(TIMEOUT - 1)) begin
                        to_flag_d = 1'b1;
                        state_d   = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= StIdle;
            type_q    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            fun_q     <= '0;
            idx_q     <= '0;
            rx_cnt_q  <= '0;
            to_cnt_q  <= '0;
            rsp_q     <= '0;
            to_flag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            fun_q     <= fun_d;
            idx_q     <= idx_d;
            rx_cnt_q  <= rx_cnt_d;
            to_cnt_q  <= to_cnt_d;
            rsp_q     <= rsp_d;
            to_flag_q <= to_flag_d;
        end
    end

    assign CMD_RDY     = (state_q == StIdle);
    assign TX_VLD      = (state_q == StSend);
    assign TX_DATA     = (state_q == StSend) ? frame_byte : '0;
    assign RSP_DATA    = rsp_q;
    assign CMD_DONE    = (state_q == StDone);
    assign RSP_TIMEOUT = (state_q == StDone) && to_flag_q;

endmodule
